// File: rtl/codificador_morse.sv
// Serialises a captured 12-character ASCII buffer as International Morse on/off keying.
// Outputs are registered one cycle behind the state; durations are exact multiples of CICLOS_UNIDAD.
module codificador_morse #(
    parameter int CICLOS_UNIDAD = 25000000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        inicio,
    input  logic [3:0]  num_carac,
    input  logic [95:0] caracteres,
    output logic        morse_out,
    output logic        ocupado,
    output logic        fin,
    output logic [3:0]  indice
);

    localparam int CW = $clog2(4 * CICLOS_UNIDAD);
    localparam logic [CW-1:0] FIN_1N = CW'(CICLOS_UNIDAD - 1);
    localparam logic [CW-1:0] FIN_3N = CW'(3 * CICLOS_UNIDAD - 1);
    localparam logic [CW-1:0] FIN_4N = CW'(4 * CICLOS_UNIDAD - 1);

    localparam logic [1:0] TIPO_NO     = 2'd0;
    localparam logic [1:0] TIPO_LETRA  = 2'd1;
    localparam logic [1:0] TIPO_ESPACIO = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        CARGA,
        SIMBOLO,
        GAP_SIMB,
        GAP_LETRA,
        GAP_PALABRA,
        FIN
    } estado_t;

    estado_t        estado, estado_sig;
    logic [CW-1:0]  cuenta;
    logic [95:0]    buffer;
    logic [3:0]     total;
    logic [4:0]     patron;
    logic [2:0]     restantes;

    logic [3:0]     sel;
    logic [7:0]     caracter;
    logic [7:0]     mayuscula;
    logic [1:0]     tipo;
    logic [2:0]     longitud;
    logic [4:0]     codigo;
    logic [4:0]     alineado;
    logic           fin_tiempo;
    logic           ultimo;

    logic           morse_d, ocupado_d, fin_d;

    // indice reaches total (possibly 12) only when no lookup is needed
    assign sel       = (indice > 4'd11) ? 4'd0 : indice;
    assign caracter  = buffer[{sel, 3'b000} +: 8];
    assign mayuscula = (caracter >= 8'h61 && caracter <= 8'h7A) ? caracter - 8'h20 : caracter;
    assign ultimo    = (indice == total - 4'd1);

    // Codes are right-aligned here, dot=0 dash=1; alignment to the MSB happens on load
    always_comb begin
        tipo     = TIPO_LETRA;
        longitud = 3'd0;
        codigo   = 5'b00000;
        case (mayuscula)
            8'h41: begin longitud = 3'd2; codigo = 5'b00001; end // A
            8'h42: begin longitud = 3'd4; codigo = 5'b01000; end // B
            8'h43: begin longitud = 3'd4; codigo = 5'b01010; end // C
            8'h44: begin longitud = 3'd3; codigo = 5'b00100; end // D
            8'h45: begin longitud = 3'd1; codigo = 5'b00000; end // E
            8'h46: begin longitud = 3'd4; codigo = 5'b00010; end // F
            8'h47: begin longitud = 3'd3; codigo = 5'b00110; end // G
            8'h48: begin longitud = 3'd4; codigo = 5'b00000; end // H
            8'h49: begin longitud = 3'd2; codigo = 5'b00000; end // I
            8'h4A: begin longitud = 3'd4; codigo = 5'b00111; end // J
            8'h4B: begin longitud = 3'd3; codigo = 5'b00101; end // K
            8'h4C: begin longitud = 3'd4; codigo = 5'b00100; end // L
            8'h4D: begin longitud = 3'd2; codigo = 5'b00011; end // M
            8'h4E: begin longitud = 3'd2; codigo = 5'b00010; end // N
            8'h4F: begin longitud = 3'd3; codigo = 5'b00111; end // O
            8'h50: begin longitud = 3'd4; codigo = 5'b00110; end // P
            8'h51: begin longitud = 3'd4; codigo = 5'b01101; end // Q
            8'h52: begin longitud = 3'd3; codigo = 5'b00010; end // R
            8'h53: begin longitud = 3'd3; codigo = 5'b00000; end // S
            8'h54: begin longitud = 3'd1; codigo = 5'b00001; end // T
            8'h55: begin longitud = 3'd3; codigo = 5'b00001; end // U
            8'h56: begin longitud = 3'd4; codigo = 5'b00001; end // V
            8'h57: begin longitud = 3'd3; codigo = 5'b00011; end // W
            8'h58: begin longitud = 3'd4; codigo = 5'b01001; end // X
            8'h59: begin longitud = 3'd4; codigo = 5'b01011; end // Y
            8'h5A: begin longitud = 3'd4; codigo = 5'b01100; end // Z
            8'h30: begin longitud = 3'd5; codigo = 5'b11111; end // 0
            8'h31: begin longitud = 3'd5; codigo = 5'b01111; end // 1
            8'h32: begin longitud = 3'd5; codigo = 5'b00111; end // 2
            8'h33: begin longitud = 3'd5; codigo = 5'b00011; end // 3
            8'h34: begin longitud = 3'd5; codigo = 5'b00001; end // 4
            8'h35: begin longitud = 3'd5; codigo = 5'b00000; end // 5
            8'h36: begin longitud = 3'd5; codigo = 5'b10000; end // 6
            8'h37: begin longitud = 3'd5; codigo = 5'b11000; end // 7
            8'h38: begin longitud = 3'd5; codigo = 5'b11100; end // 8
            8'h39: begin longitud = 3'd5; codigo = 5'b11110; end // 9
            8'h20:   tipo = TIPO_ESPACIO;
            default: tipo = TIPO_NO;
        endcase
    end

    assign alineado = codigo << (3'd5 - longitud);

    always_comb begin
        case (estado)
            SIMBOLO:     fin_tiempo = (cuenta == (patron[4] ? FIN_3N : FIN_1N));
            GAP_SIMB:    fin_tiempo = (cuenta == FIN_1N);
            GAP_LETRA:   fin_tiempo = (cuenta == FIN_3N);
            GAP_PALABRA: fin_tiempo = (cuenta == FIN_4N);
            default:     fin_tiempo = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            estado <= IDLE;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            IDLE: begin
                if (inicio) estado_sig = CARGA;
            end
            CARGA: begin
                if (indice == total) begin
                    estado_sig = FIN;
                end else if (tipo == TIPO_LETRA) begin
                    estado_sig = SIMBOLO;
                end else if (tipo == TIPO_ESPACIO) begin
                    estado_sig = GAP_PALABRA;
                end
            end
            SIMBOLO: begin
                if (fin_tiempo) begin
                    if (restantes > 3'd1) estado_sig = GAP_SIMB;
                    else if (ultimo)      estado_sig = FIN;
                    else                  estado_sig = GAP_LETRA;
                end
            end
            GAP_SIMB: begin
                if (fin_tiempo) estado_sig = SIMBOLO;
            end
            GAP_LETRA, GAP_PALABRA: begin
                if (fin_tiempo) estado_sig = CARGA;
            end
            FIN:     estado_sig = IDLE;
            default: estado_sig = IDLE;
        endcase
    end

    always_comb begin
        morse_d   = (estado == SIMBOLO);
        ocupado_d = (estado != IDLE);
        fin_d     = (estado == FIN);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            morse_out <= 1'b0;
            ocupado   <= 1'b0;
            fin       <= 1'b0;
        end else begin
            morse_out <= morse_d;
            ocupado   <= ocupado_d;
            fin       <= fin_d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cuenta    <= '0;
            buffer    <= '0;
            total     <= 4'd0;
            indice    <= 4'd0;
            patron    <= 5'd0;
            restantes <= 3'd0;
        end else begin
            cuenta <= (estado_sig != estado) ? '0 : cuenta + 1'b1;
            case (estado)
                IDLE: begin
                    if (inicio) begin
                        buffer <= caracteres;
                        total  <= (num_carac > 4'd12) ? 4'd12 : num_carac;
                        indice <= 4'd0;
                    end
                end
                CARGA: begin
                    if (indice != total) begin
                        if (tipo == TIPO_LETRA) begin
                            patron    <= alineado;
                            restantes <= longitud;
                        end else if (tipo == TIPO_NO) begin
                            indice <= indice + 4'd1;
                        end
                    end
                end
                GAP_SIMB: begin
                    if (fin_tiempo) begin
                        patron    <= {patron[3:0], 1'b0};
                        restantes <= restantes - 3'd1;
                    end
                end
                GAP_LETRA, GAP_PALABRA: begin
                    if (fin_tiempo) indice <= indice + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_codificador_morse.sv
// Bench for codificador_morse: per-cycle waveform comparison against a string-table Morse model.
module tb_codificador_morse;

    localparam int N = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        inicio = 1'b0;
    logic [3:0]  num_carac = 4'd0;
    logic [95:0] caracteres = '0;
    logic        morse_out, ocupado, fin;
    logic [3:0]  indice;

    int checks = 0;
    int failures = 0;

    bit esp_m[$];
    bit esp_f[$];
    int esp_i[$];

    codificador_morse #(.CICLOS_UNIDAD(N)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .inicio     (inicio),
        .num_carac  (num_carac),
        .caracteres (caracteres),
        .morse_out  (morse_out),
        .ocupado    (ocupado),
        .fin        (fin),
        .indice     (indice)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, esp);
        end
    endtask

    function automatic string morse_de(input logic [7:0] c);
        logic [7:0] u;
        u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
        case (u)
            "A": return ".-";    "B": return "-...";  "C": return "-.-.";
            "D": return "-..";   "E": return ".";     "F": return "..-.";
            "G": return "--.";   "H": return "....";  "I": return "..";
            "J": return ".---";  "K": return "-.-";   "L": return ".-..";
            "M": return "--";    "N": return "-.";    "O": return "---";
            "P": return ".--.";  "Q": return "--.-";  "R": return ".-.";
            "S": return "...";   "T": return "-";     "U": return "..-";
            "V": return "...-";  "W": return ".--";   "X": return "-..-";
            "Y": return "-.--";  "Z": return "--..";
            "0": return "-----"; "1": return ".----"; "2": return "..---";
            "3": return "...--"; "4": return "....-"; "5": return ".....";
            "6": return "-...."; "7": return "--..."; "8": return "---..";
            "9": return "----.";
            8'h20: return " ";
            default: return "";
        endcase
    endfunction

    task automatic empujar(input bit m, input bit f, input int idx, input int veces);
        for (int r = 0; r < veces; r++) begin
            esp_m.push_back(m);
            esp_f.push_back(f);
            esp_i.push_back(idx);
        end
    endtask

    // One entry per cycle from the load cycle onward: keying level, done flag, index (-1 = unchecked)
    task automatic modelo(input logic [95:0] chs, input int num);
        int cnt;
        bit directo;
        string s;
        cnt = (num > 12) ? 12 : num;
        directo = 1'b0;
        esp_m.delete(); esp_f.delete(); esp_i.delete();
        for (int i = 0; i < cnt; i++) begin
            s = morse_de(chs[8*i +: 8]);
            empujar(1'b0, 1'b0, -1, 1);
            directo = 1'b0;
            if (s == " ") begin
                empujar(1'b0, 1'b0, -1, 4*N);
            end else begin
                for (int j = 0; j < s.len(); j++) begin
                    empujar(1'b1, 1'b0, i, (s[j] == "-") ? 3*N : N);
                    if (j < s.len() - 1)  empujar(1'b0, 1'b0, -1, N);
                    else if (i < cnt - 1) empujar(1'b0, 1'b0, -1, 3*N);
                    else                  directo = 1'b1;
                end
            end
        end
        if (!directo) empujar(1'b0, 1'b0, -1, 1);
        empujar(1'b0, 1'b1, -1, 1);
    endtask

    task automatic ejecutar(input string tag, input logic [95:0] chs, input int num, input bit molestar);
        int largo;
        modelo(chs, num);
        largo = esp_m.size();
        @(negedge CLK);
        caracteres = chs;
        num_carac  = num[3:0];
        inicio     = 1'b1;
        @(negedge CLK);
        inicio     = 1'b0;
        caracteres = {$urandom, $urandom, $urandom};
        num_carac  = 4'($urandom_range(0, 15));
        for (int m = 0; m < largo; m++) begin
            @(negedge CLK);
            check_val({tag, "_wave"}, {29'd0, morse_out, fin, ocupado}, {29'd0, esp_m[m], esp_f[m], 1'b1});
            if (esp_i[m] >= 0) check_val({tag, "_indice"}, {28'd0, indice}, esp_i[m]);
            inicio = (molestar && (m % 7 == 3) && (m < largo - 3)) ? 1'b1 : 1'b0;
        end
        @(negedge CLK);
        check_val({tag, "_idle"}, {29'd0, morse_out, fin, ocupado}, 32'd0);
        repeat (2) @(negedge CLK);
    endtask

    function automatic logic [7:0] char_aleatorio();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0, 1, 2, 3: return 8'(8'h41 + $urandom_range(0, 25));
            4, 5:       return 8'(8'h61 + $urandom_range(0, 25));
            6:          return 8'(8'h30 + $urandom_range(0, 9));
            7:          return 8'h20;
            default:    return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        logic [95:0] chs;

        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check_val("reset_outputs", {26'd0, morse_out, fin, ocupado, 1'b0, indice}, 32'd0);

        ejecutar("E",   {88'd0, 8'h45}, 1, 1'b0);
        ejecutar("ET",  {80'd0, 8'h54, 8'h45}, 2, 1'b0);
        ejecutar("A",   {88'd0, 8'h41}, 1, 1'b0);
        ejecutar("a",   {88'd0, 8'h61}, 1, 1'b0);
        ejecutar("E_E", {72'd0, 8'h45, 8'h20, 8'h45}, 3, 1'b0);
        ejecutar("E^T", {72'd0, 8'h54, 8'h5E, 8'h45}, 3, 1'b0);
        ejecutar("trail", {72'd0, 8'h5E, 8'h20, 8'h4B}, 3, 1'b0);
        ejecutar("count0", {88'd0, 8'h45}, 0, 1'b0);
        chs = "HELLO WORLD9";
        ejecutar("num13", chs, 13, 1'b0);
        ejecutar("busy_inicio", {80'd0, 8'h30, 8'h51}, 2, 1'b1);

        // Reset in the middle of the dash of T, then restart from character 0
        @(negedge CLK);
        caracteres = {80'd0, 8'h54, 8'h45};
        num_carac  = 4'd2;
        inicio     = 1'b1;
        @(negedge CLK);
        inicio = 1'b0;
        repeat (21) @(negedge CLK);
        check_val("pre_reset_morse", {31'd0, morse_out}, 32'd1);
        check_val("pre_reset_indice", {28'd0, indice}, 32'd1);
        #3 RST = 1'b1;
        #1;
        check_val("async_reset", {26'd0, morse_out, fin, ocupado, 1'b0, indice}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        ejecutar("after_reset", {80'd0, 8'h4E, 8'h45}, 2, 1'b0);

        for (int t = 0; t < 20; t++) begin
            for (int c = 0; c < 12; c++) chs[8*c +: 8] = char_aleatorio();
            ejecutar($sformatf("rand%0d", t), chs, $urandom_range(0, 15), t[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/codificador_morse.md
Name: codificador_morse

Overview:
- Downstream stage of the 12-character ASCII input buffer (outputs reg1..reg12 plus the conta_carac character count).
- On a start pulse it snapshots the buffer and count, then walks characters in order.
- Each character is translated to International Morse and serialised as a single on/off keying line (LED/buzzer) with standard unit timing.
- Asserts a one-cycle done pulse at the end of the message.

Parameters:
CICLOS_UNIDAD, 25000000, CLK cycles per Morse time unit (N); at least 2; bench uses 4

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-high reset
inicio  in  1  start request; sampled only in IDLE
num_carac  in  4  number of valid characters, 0..12; values above 12 are clamped to 12
caracteres  in  96  flattened buffer; character i (0 = reg1 ... 11 = reg12) at bits [8i+7:8i]
morse_out  out  1  keying output; 1 = tone/LED on
ocupado  out  1  high in every state except IDLE
fin  out  1  one-cycle pulse when the message completes
indice  out  4  index of the character currently being sent (0..11)

Behaviour:
- Reset and synchronicity: one clock domain; RST is asynchronous and active-high. RST forces state IDLE and clears morse_out, ocupado, fin, indice, the unit counter and the snapshot registers. Reset mid-symbol drops morse_out immediately.
- All outputs are registered.
- Snapshot: on a CLK edge in IDLE with inicio=1, capture caracteres and min(num_carac,12), set indice=0 and go to CARGA. inicio is ignored in every other state. Buffer changes after capture have no effect.
- Lookup table (combinational, 1..5 elements, dot=0/dash=1, sent MSB-first):
  - A-Z (0x41-0x5A) and 0-9 (0x30-0x39): standard International Morse codes.
  - a-z (0x61-0x7A): treated as the uppercase letter.
  - 0x20 (space): word-gap character.
  - All other codes: unsupported.
- States:
  - IDLE: ocupado=0, morse_out=0.
  - CARGA: exactly 1 cycle, morse_out=0.
    - If indice equals the captured count, go to FIN.
    - Otherwise look up the character:
      - letter/digit: load pattern and length, go to SIMBOLO.
      - space: go to GAP_PALABRA.
      - unsupported: indice+1, stay in CARGA (costs 1 cycle, no gap emitted).
  - SIMBOLO: morse_out=1 for N cycles (dot) or 3N cycles (dash).
    - More elements remain: go to GAP_SIMB.
    - Last element and indice is the final captured index: go to FIN.
    - Otherwise: go to GAP_LETRA.
  - GAP_SIMB: morse_out=0 for N cycles, then next element, SIMBOLO.
  - GAP_LETRA: morse_out=0 for 3N cycles, then indice+1, CARGA.
  - GAP_PALABRA: morse_out=0 for 4N cycles, then indice+1, CARGA. Letter gap plus space gap plus CARGA gives a word gap of at least 7N.
  - FIN: fin=1 for exactly 1 cycle, morse_out=0, then IDLE.
- Unit counter: cleared on every state entry, so durations are exact cycle counts. Width is $clog2(3*... 4*CICLOS_UNIDAD) bits.
- Latency: inicio sampled at edge k; CARGA during k..k+1; first morse_out=1 registered at edge k+2. Each CARGA cycle adds 1 low cycle to the preceding gap.
- Count 0: inicio leads to CARGA, then FIN (fin at edge k+2); morse_out never rises.
- A trailing space or unsupported character is still processed before FIN.

Test Plan:
- N=4, "E" (0x45), num=1, inicio at edge k -> morse_out high edges k+2..k+6 (4 cycles); fin high 1 cycle immediately after; ocupado low the cycle after fin.
- N=4, "ET" (0x45,0x54), num=2 -> 4 high, 13 low (12 gap + 1 CARGA), 12 high, then fin; indice 0 then 1.
- N=4, "A" (0x41) and "a" (0x61) separately -> both give 4 high, 4 low, 12 high; no extra cycles.
- N=4, "E E" (0x45,0x20,0x45), num=3 -> 4 high, 30 low (12+1+16+1), 4 high, fin.
- N=4, "E^T" (0x45,0x5E,0x54), num=3 -> 4 high, 14 low, 12 high. num=13 with 12 chars behaves as 12.
- num=0 inicio -> fin two edges later, morse_out constant 0. inicio pulsed while ocupado -> ignored, waveform unchanged. RST asserted mid-dash -> morse_out, ocupado, indice go to 0 asynchronously; next inicio restarts from character 0.
